ieee80211_punct_encoder: RTL and testbench

Parametrised IEEE 802.11 convolutional encoder (K=7, g0=133₈, g1=171₈) with puncturing to rates 1/2, 2/3 and 3/4. It sits downstream of the scrambler in the transmit chain. It consumes WIDTH scrambled bits per AXI-Stream beat and emits one beat of up to 2·WIDTH coded bits per input beat. The code rate is selected per frame through tuser. The block succeeds the fixed rate-1/2 encoder stage by adding puncturing, configurable generators and frame-based state flushing.

---
 rtl/ieee80211_punct_encoder.sv | 108 ++++++++++
 tb/tb_ieee80211_punct_encoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ieee80211_punct_encoder.sv
// rtl/ieee80211_punct_encoder.sv - K=7 convolutional encoder with per-frame puncturing to 1/2, 2/3, 3/4
module ieee80211_punct_encoder #(
  parameter int         WIDTH = 24,
  parameter logic [6:0] G0    = 7'o133,
  parameter logic [6:0] G1    = 7'o171
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [WIDTH-1:0]     s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic [3:0]           s_axis_tuser,
  output logic [2*WIDTH-1:0]   m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic [3:0]           m_axis_tuser
);

  localparam int OW = 2 * WIDTH;

  if (WIDTH % 6 != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of 6");
  end

  // Generator bit (6-k) taps delay k; reverse so bit k of the mask taps delay k.
  localparam logic [6:0] G0_TAPS = {G0[0], G0[1], G0[2], G0[3], G0[4], G0[5], G0[6]};
  localparam logic [6:0] G1_TAPS = {G1[0], G1[1], G1[2], G1[3], G1[4], G1[5], G1[6]};

  logic [5:0]         enc_s;
  logic [1:0]         rate_q;
  logic               frame_start_q;
  logic [1:0]         raw_rate;
  logic [1:0]         cur_rate;
  logic               in_fire;
  logic [WIDTH-1:0]   enc_a;
  logic [WIDTH-1:0]   enc_b;
  logic [WIDTH:0][5:0] chain;
  logic [OW-1:0]      packed_bits;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign in_fire       = s_axis_tvalid && s_axis_tready;

  assign raw_rate = frame_start_q ? s_axis_tuser[1:0] : rate_q;
  assign cur_rate = (raw_rate == 2'd3) ? 2'd0 : raw_rate;

  assign chain[0] = enc_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [6:0] win;
    assign win          = {chain[i], s_axis_tdata[i]};
    assign enc_a[i]     = ^(win & G0_TAPS);
    assign enc_b[i]     = ^(win & G1_TAPS);
    assign chain[i + 1] = {chain[i][4:0], s_axis_tdata[i]};
  end

  always_comb begin
    packed_bits = '0;
    case (cur_rate)
      2'd1: begin
        for (int j = 0; j < WIDTH / 2; j++) begin
          packed_bits[3*j]     = enc_a[2*j];
          packed_bits[3*j + 1] = enc_b[2*j];
          packed_bits[3*j + 2] = enc_a[2*j + 1];
        end
      end
      2'd2: begin
        for (int t = 0; t < WIDTH / 3; t++) begin
          packed_bits[4*t]     = enc_a[3*t];
          packed_bits[4*t + 1] = enc_b[3*t];
          packed_bits[4*t + 2] = enc_a[3*t + 1];
          packed_bits[4*t + 3] = enc_b[3*t + 2];
        end
      end
      default: begin
        for (int i = 0; i < WIDTH; i++) begin
          packed_bits[2*i]     = enc_a[i];
          packed_bits[2*i + 1] = enc_b[i];
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      enc_s         <= '0;
      rate_q        <= 2'd0;
      frame_start_q <= 1'b1;
    end else if (in_fire) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= packed_bits;
      m_axis_tlast  <= s_axis_tlast;
      m_axis_tuser  <= {s_axis_tuser[3:2], cur_rate};
      // tlast flushes the trellis so the next frame starts from the zero state
      enc_s         <= s_axis_tlast ? 6'd0 : chain[WIDTH];
      rate_q        <= cur_rate;
      frame_start_q <= s_axis_tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ieee80211_punct_encoder.sv
// tb/tb_ieee80211_punct_encoder.sv - scoreboard bench for ieee80211_punct_encoder
module tb_ieee80211_punct_encoder;

  localparam logic [6:0] TG0 = 7'o133;
  localparam logic [6:0] TG1 = 7'o171;

  typedef struct packed {
    logic [47:0] d;
    logic        l;
    logic [3:0]  u;
  } beat_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [23:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [3:0]  s_axis_tuser;
  logic [47:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [3:0]  m_axis_tuser;

  int    checks = 0;
  int    passed = 0;
  int    mode   = 0;
  beat_t exp_q[$];

  logic [5:0] ms;
  logic [1:0] mrate;
  logic       mstart;

  ieee80211_punct_encoder #(.WIDTH(24)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic model_reset();
    ms = 6'd0;
    mrate = 2'd0;
    mstart = 1'b1;
  endtask

  // Reference: taps looked up by absolute delay, emission driven by a per-rate puncture pattern.
  task automatic model_step(input logic [23:0] d, input logic l, input logic [3:0] u, output beat_t e);
    logic [1:0] r;
    logic       av, bv, dk;
    int         p;
    r = mstart ? u[1:0] : mrate;
    if (r == 2'd3) r = 2'd0;
    e = '0;
    p = 0;
    for (int i = 0; i < 24; i++) begin
      av = 1'b0;
      bv = 1'b0;
      for (int k = 0; k < 7; k++) begin
        dk = (k <= i) ? d[i-k] : ms[k-1-i];
        av = av ^ (TG0[6-k] & dk);
        bv = bv ^ (TG1[6-k] & dk);
      end
      if (r == 2'd0 || (r == 2'd1 && i % 2 == 0) || (r == 2'd2 && i % 3 == 0)) begin
        e.d[p] = av; e.d[p+1] = bv; p += 2;
      end else if ((r == 2'd1) || (r == 2'd2 && i % 3 == 1)) begin
        e.d[p] = av; p += 1;
      end else begin
        e.d[p] = bv; p += 1;
      end
    end
    e.l = l;
    e.u = {u[3:2], r};
    for (int k = 0; k < 6; k++) ms[k] = d[23-k];
    if (l) ms = 6'd0;
    mrate = r;
    mstart = l;
  endtask

  task automatic send(input logic [23:0] d, input logic l, input logic [3:0] u,
                      input bit hand, input logic [47:0] hd, input logic [3:0] hu);
    beat_t e;
    int    cnt;
    model_step(d, l, u, e);
    if (hand) begin
      e.d = hd;
      e.u = hu;
    end
    exp_q.push_back(e);
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    cnt = 0;
    #4;
    while (!s_axis_tready && cnt < 1000) begin
      #10;
      cnt++;
    end
    if (cnt >= 1000) begin
      checks++;
      $display("FAIL send_timeout: s_axis_tready stayed 0 for %0d cycles", cnt);
    end
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(negedge aclk);
      if (mode == 0) m_axis_tready = 1'b1;
      else if (mode == 2) m_axis_tready = 1'b0;
      else m_axis_tready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    beat_t got, exp, held;
    bit    stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge aclk);
      #4;
      if (!aresetn) begin
        stalled = 1'b0;
      end else begin
        got = '{m_axis_tdata, m_axis_tlast, m_axis_tuser};
        if (stalled) check("stall_stable", 64'(got), 64'(held));
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_beat: got %h with empty scoreboard", got);
          end else begin
            exp = exp_q.pop_front();
            check("beat", 64'(got), 64'(exp));
          end
        end
        stalled = m_axis_tvalid && !m_axis_tready;
        held = got;
      end
    end
  end

  initial begin
    int cnt;
    model_reset();
    aresetn = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tlast = 1'b0;
    s_axis_tuser = '0;
    repeat (3) @(negedge aclk);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tuser", 64'(m_axis_tuser), 64'd0);
    check("rst_tready", 64'(s_axis_tready), 64'd1);
    aresetn = 1'b1;
    @(negedge aclk);

    send(24'h000000, 1'b1, 4'h0, 1'b1, 48'h0, 4'h0);
    check("latency_tvalid", 64'(m_axis_tvalid), 64'd1);
    send(24'h000000, 1'b1, 4'h1, 1'b1, 48'h0, 4'h1);
    send(24'h000000, 1'b1, 4'h2, 1'b1, 48'h0, 4'h2);
    send(24'h000000, 1'b1, 4'h3, 1'b1, 48'h0, 4'h0);

    send(24'h000001, 1'b1, 4'h0, 1'b1, 48'h0000_0000_34FB, 4'h0);
    send(24'h000001, 1'b1, 4'h9, 1'b1, 48'h0000_0000_073B, 4'h9);
    send(24'h000001, 1'b1, 4'h6, 1'b1, 48'h0000_0000_033B, 4'h6);

    send(24'h800000, 1'b0, 4'h0, 1'b1, 48'hC000_0000_0000, 4'h0);
    send(24'h000000, 1'b1, 4'h0, 1'b1, 48'h0000_0000_0D3E, 4'h0);
    send(24'h000000, 1'b1, 4'h0, 1'b1, 48'h0, 4'h0);

    send(24'h000001, 1'b0, 4'h1, 1'b1, 48'h0000_0000_073B, 4'h1);
    send(24'h000001, 1'b1, 4'hC, 1'b1, 48'h0000_0000_073B, 4'hD);

    mode = 1;
    for (int i = 0; i < 100; i++) begin
      send(24'($urandom), (i == 99) || ($urandom_range(0, 5) == 0),
           4'($urandom_range(0, 15)), 1'b0, 48'h0, 4'h0);
    end

    cnt = 0;
    while (exp_q.size() != 0 && cnt < 2000) begin
      @(negedge aclk);
      cnt++;
    end
    mode = 0;
    @(negedge aclk);
    @(negedge aclk);

    mode = 2;
    send(24'hABCDEF, 1'b0, 4'h0, 1'b1, 48'h0, 4'h0);
    aresetn = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    check("midreset_tvalid", 64'(m_axis_tvalid), 64'd0);
    mode = 0;
    send(24'h000001, 1'b1, 4'h0, 1'b1, 48'h0000_0000_34FB, 4'h0);

    cnt = 0;
    while (exp_q.size() != 0 && cnt < 2000) begin
      @(negedge aclk);
      cnt++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
